// File: rtl/image_rd_if_if.sv
// MIG read-port and pixel-stream bundle used by image_rd_if.
interface image_rd_if_if;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [29:0] mem_cmd_byte_addr;
    logic [5:0]  mem_cmd_burst_len;
    logic        mem_cmd_full;
    logic        mem_rd_en;
    logic [63:0] mem_rd_data;
    logic        mem_rd_empty;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_last;

    modport master (
        output mem_cmd_en, mem_cmd_instr, mem_cmd_byte_addr, mem_cmd_burst_len,
        input  mem_cmd_full,
        output mem_rd_en,
        input  mem_rd_data, mem_rd_empty,
        output pix_valid, pix_data, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_byte_addr, mem_cmd_burst_len,
        output mem_cmd_full,
        input  mem_rd_en,
        output mem_rd_data, mem_rd_empty,
        input  pix_valid, pix_data, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/image_rd_if.sv
// Frame read engine: issues MIG read bursts, pops 64-bit words and
// unpacks them MSB-first into an 8bpp or 16bpp pixel stream.
module image_rd_if #(
    parameter int BURST_LEN       = 32,
    parameter int BURST_LEN_BYTES = 256,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          packing_mode,
    input  logic          start,
    input  logic [29:0]   start_addr,
    input  logic [15:0]   num_bursts,
    output logic          busy,
    output logic          frame_done,
    image_rd_if_if.master bus
);
    localparam int WCNT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_mode;
    logic [29:0]         r_addr;
    logic [15:0]         r_nb;
    logic [15:0]         r_issued;
    logic [15:0]         r_popped;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [63:0]         r_buf;
    logic                r_buf_full;
    logic [2:0]          r_idx;
    logic [24:0]         r_pix_cnt;
    logic                r_pix_valid;
    logic [15:0]         r_pix_data;
    logic                r_pix_last;

    logic                w_accept;
    logic                w_run;
    logic                w_cmd;
    logic                w_rd;
    logic                w_adv;
    logic                w_take;
    logic                w_buf_last;
    logic                w_fin;
    logic                w_burst_end;
    logic [15:0]         w_outst;
    logic [24:0]         w_total;
    logic [5:0]          w_b8;
    logic [5:0]          w_b16;
    logic [15:0]         w_pix;

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (num_bursts == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_fin) w_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_run       = (r_state == S_RUN);
    assign w_outst     = r_issued - r_popped;
    assign w_cmd       = w_run && !bus.mem_cmd_full && (r_issued < r_nb)
                         && (w_outst < 16'(MAX_OUTSTANDING));
    assign w_adv       = !r_pix_valid || bus.pix_ready;
    assign w_take      = w_run && w_adv && r_buf_full;
    assign w_buf_last  = (r_idx == (r_mode ? 3'd3 : 3'd7));
    // A new word may load in the same cycle the buffer's last pixel leaves
    assign w_rd        = w_run && !bus.mem_rd_empty && (r_popped < r_nb)
                         && (!r_buf_full || (w_take && w_buf_last));
    assign w_fin       = w_run && r_pix_valid && bus.pix_ready && r_pix_last;
    assign w_burst_end = (r_wcnt == WCNT_W'(BURST_LEN - 1));
    assign w_total     = 25'(r_nb) * 25'(BURST_LEN) * (r_mode ? 25'd4 : 25'd8);
    assign w_b8        = 6'd63 - {r_idx, 3'd0};
    assign w_b16       = 6'd63 - {r_idx[1:0], 4'd0};
    assign w_pix       = r_mode ? r_buf[w_b16 -: 16] : {8'h00, r_buf[w_b8 -: 8]};

    assign bus.mem_cmd_en        = w_cmd;
    assign bus.mem_cmd_instr     = 3'b001;
    assign bus.mem_cmd_byte_addr = r_addr;
    assign bus.mem_cmd_burst_len = 6'(BURST_LEN - 1);
    assign bus.mem_rd_en         = w_rd;
    assign bus.pix_valid         = r_pix_valid;
    assign bus.pix_data          = r_pix_data;
    assign bus.pix_last          = r_pix_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= 1'b0;
            r_addr      <= 30'd0;
            r_nb        <= 16'd0;
            r_issued    <= 16'd0;
            r_popped    <= 16'd0;
            r_wcnt      <= '0;
            r_buf       <= 64'd0;
            r_buf_full  <= 1'b0;
            r_idx       <= 3'd0;
            r_pix_cnt   <= 25'd0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= 16'd0;
            r_pix_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode     <= packing_mode;
                r_addr     <= start_addr;
                r_nb       <= num_bursts;
                r_issued   <= 16'd0;
                r_popped   <= 16'd0;
                r_wcnt     <= '0;
                r_pix_cnt  <= 25'd0;
                r_buf_full <= 1'b0;
                r_idx      <= 3'd0;
            end
            if (w_cmd) begin
                r_issued <= r_issued + 16'd1;
                r_addr   <= r_addr + 30'(BURST_LEN_BYTES);
            end
            if (w_rd) begin
                r_wcnt <= w_burst_end ? '0 : r_wcnt + 1'b1;
                if (w_burst_end) r_popped <= r_popped + 16'd1;
            end
            if (w_rd) begin
                r_buf      <= bus.mem_rd_data;
                r_buf_full <= 1'b1;
                r_idx      <= 3'd0;
            end else if (w_take) begin
                if (w_buf_last) r_buf_full <= 1'b0;
                else            r_idx      <= r_idx + 3'd1;
            end
            if (w_run && w_adv) begin
                r_pix_valid <= r_buf_full;
                if (r_buf_full) begin
                    r_pix_data <= w_pix;
                    r_pix_last <= (r_pix_cnt == w_total - 25'd1);
                    r_pix_cnt  <= r_pix_cnt + 25'd1;
                end else begin
                    r_pix_last <= 1'b0;
                end
            end else if (!w_run) begin
                r_pix_valid <= 1'b0;
                r_pix_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_image_rd_if.sv
// Frame-read bench: MIG/FIFO responder, pixel scoreboard built from
// the unpacking rules, directed frames with randomized data and flow.
module tb_image_rd_if;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        packing_mode;
    logic        start;
    logic [29:0] start_addr;
    logic [15:0] num_bursts;
    logic        busy;
    logic        frame_done;

    image_rd_if_if bus();

    image_rd_if dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .packing_mode (packing_mode),
        .start        (start),
        .start_addr   (start_addr),
        .num_bursts   (num_bursts),
        .busy         (busy),
        .frame_done   (frame_done),
        .bus          (bus)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    int full_force = 0;
    int full_rand = 0;
    int hold_rand = 0;
    int data_rand = 0;

    logic        f_mode = 1'b0;
    logic [29:0] f_addr = 30'd0;
    int f_nb = 0;
    int f_total = 0;
    int cmd_count = 0;
    int popped_words = 0;
    int acc_count = 0;
    int done_count = 0;
    int valid_count = 0;
    int cycle = 0;
    int first_free = -1;
    int first_cmd = -1;

    logic [15:0] exp_q[$];
    logic [63:0] fifo_q[$];
    logic ev_cmd = 1'b0;
    logic ev_rd = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each stored word yields its pixels most-significant field first
    task automatic push_word(input logic [63:0] w);
        fifo_q.push_back(w);
        if (f_mode) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(w[63-16*k -: 16]);
        end else begin
            for (int k = 0; k < 8; k++) exp_q.push_back({8'h00, w[63-8*k -: 8]});
        end
    endtask

    initial begin : responder
        logic [63:0] tmp;
        bus.mem_cmd_full = 1'b0;
        bus.mem_rd_empty = 1'b1;
        bus.mem_rd_data  = 64'd0;
        bus.pix_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                fifo_q.delete();
                ev_cmd = 1'b0;
                ev_rd  = 1'b0;
            end else begin
                if (ev_rd && fifo_q.size() > 0) tmp = fifo_q.pop_front();
                if (ev_cmd) begin
                    for (int i = 0; i < 32; i++)
                        push_word(data_rand != 0 ? {$urandom, $urandom}
                                                 : 64'h0001020304050607);
                end
                ev_cmd = 1'b0;
                ev_rd  = 1'b0;
            end
            bus.mem_rd_empty = (fifo_q.size() == 0) ||
                               (hold_rand != 0 && $urandom_range(0, 2) == 0);
            bus.mem_rd_data  = (fifo_q.size() > 0) ? fifo_q[0] : 64'hDEADBEEFDEADBEEF;
            case (ready_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ($urandom_range(0, 3) != 0);
                2:       bus.pix_ready = ~bus.pix_ready;
                default: bus.pix_ready = 1'b0;
            endcase
            bus.mem_cmd_full = (full_force != 0) ||
                               (full_rand != 0 && $urandom_range(0, 3) == 0);
        end
    end

    initial begin : monitor
        logic [29:0] ea;
        logic [15:0] ep;
        forever begin
            @(negedge clk);
            cycle++;
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.mem_cmd_en) begin
                    ea = f_addr + 30'(cmd_count) * 30'd256;
                    chk("cmd_while_full", bus.mem_cmd_full, 0);
                    chk("cmd_addr", bus.mem_cmd_byte_addr, ea);
                    chk("outstanding", (cmd_count - popped_words / 32) < 2, 1);
                    if (first_cmd < 0) first_cmd = cycle;
                    cmd_count++;
                    ev_cmd = 1'b1;
                end
                if (bus.mem_rd_en) begin
                    chk("rd_while_empty", bus.mem_rd_empty, 0);
                    popped_words++;
                    ev_rd = 1'b1;
                end
                if (prev_stall) begin
                    chk("stall_valid", bus.pix_valid, 1);
                    chk("stall_data", bus.pix_data, prev_data);
                    chk("stall_last", bus.pix_last, prev_last);
                end
                if (bus.pix_valid && bus.pix_ready) begin
                    chk("pixel_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        ep = exp_q.pop_front();
                        chk("pix_data", bus.pix_data, ep);
                    end
                    chk("pix_last", bus.pix_last, acc_count == f_total - 1);
                    acc_count++;
                end
                if (bus.pix_valid) valid_count++;
                prev_stall = bus.pix_valid && !bus.pix_ready;
                prev_data  = bus.pix_data;
                prev_last  = bus.pix_last;
                if (frame_done) done_count++;
                if (busy && !bus.mem_cmd_full && first_free < 0) first_free = cycle;
            end
        end
    end

    task automatic run_start(input logic m, input logic [29:0] a, input int nb);
        @(posedge clk);
        #1;
        f_mode = m;
        f_addr = a;
        f_nb = nb;
        f_total = nb * 32 * (m ? 4 : 8);
        cmd_count = 0;
        popped_words = 0;
        acc_count = 0;
        done_count = 0;
        valid_count = 0;
        first_free = -1;
        first_cmd = -1;
        exp_q.delete();
        packing_mode = m;
        start_addr = a;
        num_bursts = 16'(nb);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic finish_frame(input string tag);
        int n = 0;
        while (done_count == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done_count != 0, 1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done_once"}, done_count, 1);
        chk({tag, "_pix_count"}, acc_count, f_total);
        chk({tag, "_cmd_count"}, cmd_count, f_nb);
        chk({tag, "_exp_left"}, exp_q.size(), 0);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_valid_low"}, bus.pix_valid, 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        start = 1'b0;
        packing_mode = 1'b0;
        start_addr = 30'd0;
        num_bursts = 16'd0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cmd_en", bus.mem_cmd_en, 0);
        chk("rst_instr", bus.mem_cmd_instr, 3'b001);
        chk("rst_blen", bus.mem_cmd_burst_len, 6'd31);
        chk("rst_addr", bus.mem_cmd_byte_addr, 0);
        chk("rst_rd_en", bus.mem_rd_en, 0);
        chk("rst_valid", bus.pix_valid, 0);
        chk("rst_data", bus.pix_data, 0);
        chk("rst_last", bus.pix_last, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 8bpp single burst, constant data, plus an ignored start mid-frame
        ready_mode = 0;
        data_rand = 0;
        run_start(1'b0, 30'h0000100, 1);
        repeat (50) @(posedge clk);
        #1;
        num_bursts = 16'd5;
        start_addr = 30'h0ABCDE0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_frame("t1");

        // 16bpp, address wrap, random flow control on every side
        ready_mode = 1;
        hold_rand = 1;
        full_rand = 1;
        data_rand = 1;
        run_start(1'b1, 30'h3FFFFF00, 3);
        finish_frame("t2");
        hold_rand = 0;
        full_rand = 0;

        // Alternating ready with a 20-cycle stall in the middle
        ready_mode = 2;
        run_start(1'b0, 30'h0000400, 2);
        repeat (37) @(posedge clk);
        #1;
        ready_mode = 3;
        repeat (20) @(posedge clk);
        #1;
        ready_mode = 2;
        finish_frame("t3");

        // Command FIFO full for the first 10 cycles
        ready_mode = 0;
        full_force = 1;
        run_start(1'b1, 30'h0001000, 1);
        repeat (10) @(posedge clk);
        #1;
        full_force = 0;
        finish_frame("t4");
        chk("t4_first_cmd", first_cmd, first_free);

        // Empty frame
        run_start(1'b0, 30'h0002000, 0);
        @(negedge clk);
        chk("t5_done_pulse", frame_done, 1);
        repeat (3) @(negedge clk);
        chk("t5_done_once", done_count, 1);
        chk("t5_no_cmd", cmd_count, 0);
        chk("t5_no_valid", valid_count, 0);
        chk("t5_busy_low", busy, 0);

        // Reset mid-frame, then a clean frame
        run_start(1'b0, 30'h0003000, 2);
        n = 0;
        while (acc_count < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_100", acc_count >= 100, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", frame_done, 0);
        chk("t6_rst_cmd_en", bus.mem_cmd_en, 0);
        chk("t6_rst_addr", bus.mem_cmd_byte_addr, 0);
        chk("t6_rst_rd_en", bus.mem_rd_en, 0);
        chk("t6_rst_valid", bus.pix_valid, 0);
        chk("t6_rst_data", bus.pix_data, 0);
        chk("t6_rst_last", bus.pix_last, 0);
        chk("t6_rst_instr", bus.mem_cmd_instr, 3'b001);
        chk("t6_rst_blen", bus.mem_cmd_burst_len, 6'd31);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready_mode = 1;
        run_start(1'b1, 30'h0004000, 2);
        finish_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
